// File: rtl/pll_reconfig_sequencer.sv
// PLL reconfiguration sequencer.
// Programs an Avalon-MM PLL reconfig management port with a fixed command list
// (mode, M, N, NUM_C C counters, bandwidth, charge pump, start), then polls the
// status register until bit0 is set or the poll timeout expires.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 single-cycle request, accepted only when idle
//   m_cfg, n_cfg, c_cfg   counter words, latched when start is accepted
//   mgmt_*                Avalon-MM master towards the PLL reconfig block
//   busy                  sequence in progress
//   done, error           one-cycle completion / timeout pulses
module pll_reconfig_sequencer #(
   parameter int unsigned NUM_C          = 1,
   parameter int unsigned WRITE_GAP      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned BW_SETTING     = 6,
   parameter int unsigned CP_SETTING     = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [17:0]          m_cfg,
   input  logic [17:0]          n_cfg,
   input  logic [18*NUM_C-1:0]  c_cfg,
   input  logic                 mgmt_waitrequest,
   input  logic [31:0]          mgmt_readdata,
   output logic                 mgmt_read,
   output logic                 mgmt_write,
   output logic [5:0]           mgmt_address,
   output logic [31:0]          mgmt_writedata,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WRITE     = 3'd1;
   localparam logic [2:0] S_GAP       = 3'd2;
   localparam logic [2:0] S_POLL_RD   = 3'd3;
   localparam logic [2:0] S_POLL_WAIT = 3'd4;

   // Command index layout: 0 mode, 1 M, 2 N, 3..2+NUM_C C[k], then BW, CP, START.
   localparam logic [3:0]  IDX_BW    = 4'(3 + NUM_C);
   localparam logic [3:0]  IDX_CP    = 4'(4 + NUM_C);
   localparam logic [3:0]  IDX_START = 4'(5 + NUM_C);
   localparam logic [3:0]  GAP_LOAD  = 4'(WRITE_GAP);
   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   logic [2:0]           state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [3:0]           gap_q, gap_d;
   logic [31:0]          tmo_q, tmo_d;
   logic [17:0]          m_q, m_d, n_q, n_d;
   logic [18*NUM_C-1:0]  c_q, c_d;
   logic                 read_q, read_d, write_q, write_d;
   logic [5:0]           addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;

   logic [3:0]  cmd_sel;
   logic [4:0]  c_k;
   logic [17:0] c_word;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        issue;
   logic        unused_rd;

   assign unused_rd = ^mgmt_readdata[31:1];

   // Address/data of the command to present next (index 0 when leaving idle).
   always_comb begin
      cmd_sel  = (state_q == S_IDLE) ? 4'd0 : idx_q + 4'd1;
      c_k      = {1'b0, cmd_sel} - 5'd3;
      c_word   = 18'h0;
      cmd_addr = 6'h00;
      cmd_data = 32'h0;
      for (int k = 0; k < NUM_C; k++) begin
         if (c_k == 5'(k)) c_word = c_q[18*k +: 18];
      end
      if (cmd_sel == 4'd0) begin
         cmd_addr = 6'h00;
         cmd_data = 32'd1;
      end else if (cmd_sel == 4'd1) begin
         cmd_addr = 6'h04;
         cmd_data = {14'b0, m_q};
      end else if (cmd_sel == 4'd2) begin
         cmd_addr = 6'h03;
         cmd_data = {14'b0, n_q};
      end else if (cmd_sel < IDX_BW) begin
         cmd_addr = 6'h05;
         cmd_data = {9'b0, c_k, c_word};
      end else if (cmd_sel == IDX_BW) begin
         cmd_addr = 6'h08;
         cmd_data = 32'(BW_SETTING);
      end else if (cmd_sel == IDX_CP) begin
         cmd_addr = 6'h09;
         cmd_data = 32'(CP_SETTING);
      end else if (cmd_sel == IDX_START) begin
         cmd_addr = 6'h02;
         cmd_data = 32'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      m_d     = m_q;
      n_d     = n_q;
      c_d     = c_q;
      read_d  = read_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = 1'b0;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done/error pulse belongs to the
            // finishing sequence and is dropped.
            if (start && !done_q && !error_q) begin
               m_d     = m_cfg;
               n_d     = n_cfg;
               c_d     = c_cfg;
               busy_d  = 1'b1;
               idx_d   = 4'd0;
               write_d = 1'b1;
               addr_d  = cmd_addr;
               wdata_d = cmd_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!mgmt_waitrequest) begin
               if (WRITE_GAP == 0) begin
                  issue = 1'b1;
               end else begin
                  write_d = 1'b0;
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q <= 4'd1) issue = 1'b1;
            else               gap_d = gap_q - 4'd1;
         end
         S_POLL_RD: begin
            tmo_d = tmo_q + 32'd1;
            // Successful acceptance is checked first so it wins over expiry.
            if (!mgmt_waitrequest && mgmt_readdata[0]) begin
               read_d  = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (tmo_q >= TMO_LAST) begin
               read_d  = 1'b0;
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!mgmt_waitrequest) begin
               read_d  = 1'b0;
               state_d = S_POLL_WAIT;
            end
         end
         S_POLL_WAIT: begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_q >= TMO_LAST) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               read_d  = 1'b1;
               state_d = S_POLL_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         if (idx_q == IDX_START) begin
            write_d = 1'b0;
            read_d  = 1'b1;
            addr_d  = 6'h01;
            tmo_d   = 32'd0;
            state_d = S_POLL_RD;
         end else begin
            idx_d   = idx_q + 4'd1;
            write_d = 1'b1;
            addr_d  = cmd_addr;
            wdata_d = cmd_data;
            state_d = S_WRITE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         m_q     <= '0;
         n_q     <= '0;
         c_q     <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         m_q     <= m_d;
         n_q     <= n_d;
         c_q     <= c_d;
         read_q  <= read_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign mgmt_read      = read_q;
   assign mgmt_write     = write_q;
   assign mgmt_address   = addr_q;
   assign mgmt_writedata = wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Testbench for pll_reconfig_sequencer: randomized sequences against a
// cycle-level transaction model, with a queue-based scoreboard monitor.
module tb_pll_reconfig_sequencer;

   localparam int unsigned NUM_C = 3;
   localparam int unsigned GAP   = 2;
   localparam int unsigned TMO   = 16;
   localparam int unsigned BW    = 6;
   localparam int unsigned CP    = 3;
   localparam int          NW    = 6 + NUM_C;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [17:0]         m_cfg = '0;
   logic [17:0]         n_cfg = '0;
   logic [18*NUM_C-1:0] c_cfg = '0;
   logic                mgmt_waitrequest = 1'b0;
   logic [31:0]         mgmt_readdata = '0;
   logic                mgmt_read, mgmt_write;
   logic [5:0]          mgmt_address;
   logic [31:0]         mgmt_writedata;
   logic                busy, done, error;

   pll_reconfig_sequencer #(
      .NUM_C          (NUM_C),
      .WRITE_GAP      (GAP),
      .TIMEOUT_CYCLES (TMO),
      .BW_SETTING     (BW),
      .CP_SETTING     (CP)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .m_cfg            (m_cfg),
      .n_cfg            (n_cfg),
      .c_cfg            (c_cfg),
      .mgmt_waitrequest (mgmt_waitrequest),
      .mgmt_readdata    (mgmt_readdata),
      .mgmt_read        (mgmt_read),
      .mgmt_write       (mgmt_write),
      .mgmt_address     (mgmt_address),
      .mgmt_writedata   (mgmt_writedata),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;
   typedef struct {
      bit is_err;
      int cyc;
   } evt_t;

   wr_t  exp_wr[$];
   evt_t exp_evt[$];
   int   checks = 0;
   int   failures = 0;
   int   busy_from = 0;
   int   busy_to = 0;
   bit   quiet = 1'b0;
   int   wst[16];
   int   rdst[16];
   int   nfail = 0;

   // Bus responder: per-command waitrequest stall lengths, read status bit0.
   int wi = 0, ri = 0, left = 0;
   bit loaded = 1'b0;
   always @(posedge clk) begin
      #1;
      mgmt_readdata = $urandom;
      if (reset || !busy) begin
         wi = 0;
         ri = 0;
         loaded = 1'b0;
         mgmt_waitrequest = 1'b0;
      end else if (mgmt_write || mgmt_read) begin
         if (!loaded) begin
            if (mgmt_write) left = (wi < 16) ? wst[wi] : 0;
            else            left = (ri < 16) ? rdst[ri] : 0;
            loaded = 1'b1;
         end
         if (left > 0) begin
            mgmt_waitrequest = 1'b1;
            left--;
         end else begin
            mgmt_waitrequest = 1'b0;
            loaded = 1'b0;
            if (mgmt_read) begin
               mgmt_readdata[0] = (ri >= nfail);
               ri++;
            end else begin
               wi++;
            end
         end
      end else begin
         mgmt_waitrequest = 1'b0;
      end
   end

   // Monitor / scoreboard.
   bit          rst_d = 1'b0;
   bit          prev_stall = 1'b0;
   logic [5:0]  prev_a = '0;
   logic [31:0] prev_d = '0;
   always @(negedge clk) begin
      if (rst_d) begin
         checks++;
         if ({mgmt_read, mgmt_write, busy, done, error} != 5'b0 || mgmt_address != 6'h0 ||
             mgmt_writedata != 32'h0) begin
            failures++;
            $display("FAIL reset_state: rd=%0b wr=%0b busy=%0b done=%0b err=%0b a=%h d=%h, want 0",
                     mgmt_read, mgmt_write, busy, done, error, mgmt_address, mgmt_writedata);
         end
      end
      if (!reset) begin
         checks++;
         if (busy !== (cyc >= busy_from && cyc < busy_to)) begin
            failures++;
            $display("FAIL busy: cyc=%0d got=%0b want=%0b", cyc, busy,
                     (cyc >= busy_from && cyc < busy_to));
         end
         if (quiet) begin
            checks++;
            if (mgmt_write || mgmt_read || done || error) begin
               failures++;
               $display("FAIL quiet: cyc=%0d wr=%0b rd=%0b done=%0b err=%0b, want all 0",
                        cyc, mgmt_write, mgmt_read, done, error);
            end
         end
         if (mgmt_read || mgmt_write) begin
            checks++;
            if ((mgmt_read && mgmt_write) || (mgmt_read && mgmt_address != 6'h01)) begin
               failures++;
               $display("FAIL strobe: cyc=%0d rd=%0b wr=%0b addr=%h, want one strobe, read addr 01",
                        cyc, mgmt_read, mgmt_write, mgmt_address);
            end
         end
         if (prev_stall) begin
            checks++;
            if (!mgmt_write || mgmt_address != prev_a || mgmt_writedata != prev_d) begin
               failures++;
               $display("FAIL wr_hold: cyc=%0d wr=%0b a=%h d=%h, want wr=1 a=%h d=%h",
                        cyc, mgmt_write, mgmt_address, mgmt_writedata, prev_a, prev_d);
            end
         end
         if (mgmt_write && !mgmt_waitrequest) begin
            checks++;
            if (exp_wr.size() == 0) begin
               failures++;
               $display("FAIL wr_extra: cyc=%0d a=%h d=%h, want no write",
                        cyc, mgmt_address, mgmt_writedata);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               if (mgmt_address != e.addr || mgmt_writedata != e.data || cyc != e.cyc) begin
                  failures++;
                  $display("FAIL wr_cmd: got a=%h d=%h cyc=%0d, want a=%h d=%h cyc=%0d",
                           mgmt_address, mgmt_writedata, cyc, e.addr, e.data, e.cyc);
               end
            end
         end
         while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL wr_missing: got none by cyc=%0d, want a=%h d=%h at cyc=%0d",
                     cyc, exp_wr[0].addr, exp_wr[0].data, exp_wr[0].cyc);
            void'(exp_wr.pop_front());
         end
         if (done || error) begin
            checks++;
            if (exp_evt.size() == 0) begin
               failures++;
               $display("FAIL evt_extra: cyc=%0d done=%0b err=%0b, want none", cyc, done, error);
            end else begin
               evt_t v;
               v = exp_evt.pop_front();
               if (done == v.is_err || error != v.is_err || cyc != v.cyc) begin
                  failures++;
                  $display("FAIL evt: got done=%0b err=%0b cyc=%0d, want err=%0b cyc=%0d",
                           done, error, cyc, v.is_err, v.cyc);
               end
            end
         end
         while (exp_evt.size() > 0 && exp_evt[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL evt_missing: got none by cyc=%0d, want err=%0b at cyc=%0d",
                     cyc, exp_evt[0].is_err, exp_evt[0].cyc);
            void'(exp_evt.pop_front());
         end
      end
      prev_stall = !reset && mgmt_write && mgmt_waitrequest;
      prev_a = mgmt_address;
      prev_d = mgmt_writedata;
      rst_d = reset;
   end

   function automatic logic [18*NUM_C-1:0] rand_c();
      logic [18*NUM_C-1:0] c;
      for (int k = 0; k < NUM_C; k++) c[18*k +: 18] = 18'($urandom);
      return c;
   endfunction

   // Issue start and push the modelled write list and terminal event.
   task automatic launch(input logic [17:0] m, input logic [17:0] n,
                         input logic [18*NUM_C-1:0] c, output int s);
      int   t, o, acc;
      wr_t  e;
      evt_t ev;
      @(posedge clk);
      #1;
      m_cfg = m;
      n_cfg = n;
      c_cfg = c;
      start = 1'b1;
      s = cyc;
      t = s + 1;
      for (int i = 0; i < NW; i++) begin
         if (i == 0)               begin e.addr = 6'h00; e.data = 32'd1; end
         else if (i == 1)          begin e.addr = 6'h04; e.data = 32'(m); end
         else if (i == 2)          begin e.addr = 6'h03; e.data = 32'(n); end
         else if (i < 3 + NUM_C) begin
            e.addr = 6'h05;
            e.data = 32'(i - 3) * 32'h40000 + 32'(c[18*(i-3) +: 18]);
         end
         else if (i == 3 + NUM_C)  begin e.addr = 6'h08; e.data = BW; end
         else if (i == 4 + NUM_C)  begin e.addr = 6'h09; e.data = CP; end
         else                      begin e.addr = 6'h02; e.data = 32'd1; end
         acc = t + wst[i];
         e.cyc = acc;
         exp_wr.push_back(e);
         t = acc + 1 + GAP;
      end
      // t is now the first poll cycle; offsets below are relative to it.
      ev.is_err = 1'b1;
      ev.cyc = t + TMO;
      o = 0;
      for (int j = 0; j < 16; j++) begin
         acc = o + rdst[j];
         if (acc >= TMO) break;
         if (j >= nfail) begin
            ev.is_err = 1'b0;
            ev.cyc = t + acc + 1;
            break;
         end
         o = acc + 2;
      end
      exp_evt.push_back(ev);
      busy_from = s + 1;
      busy_to = ev.cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      m_cfg = 18'($urandom);
      n_cfg = 18'($urandom);
      c_cfg = rand_c();
   endtask

   task automatic finish_txn(input int s, input bit mid, input int rst_at);
      int lim = 0;
      while ((exp_wr.size() != 0 || exp_evt.size() != 0) && lim < 2000) begin
         @(posedge clk);
         #1;
         lim++;
         start = mid && (cyc == s + 4);
         if (rst_at > 0 && cyc == s + rst_at) begin
            reset = 1'b1;
            for (int i = exp_wr.size() - 1; i >= 0; i--) begin
               if (exp_wr[i].cyc >= cyc) exp_wr.delete(i);
            end
            exp_evt.delete();
            busy_to = cyc;
         end
      end
      if (lim >= 2000) begin
         $display("FAIL txn_hang: queues not drained after %0d cycles", lim);
         $fatal(1, "bench stuck");
      end
      start = 1'b0;
      if (reset) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int s;
      for (int i = 0; i < 16; i++) begin
         wst[i] = 0;
         rdst[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Directed: reference configuration, three C channels.
      nfail = 0;
      launch(18'h0_25_25, 18'h2_03_02, {18'h00303, 18'h00202, 18'h00101}, s);
      finish_txn(s, 1'b0, 0);

      // M write stalled 4 cycles, three not-ready reads, start while busy.
      wst[1] = 4;
      nfail = 3;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b1, 0);
      wst[1] = 0;

      // Status never ready: timeout.
      nfail = 99;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b0, 0);

      // Ready read accepted on the last counter cycle: done wins.
      nfail = 0;
      rdst[0] = TMO - 1;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b0, 0);

      // Ready read stalled one cycle too long: timeout.
      rdst[0] = TMO;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b0, 0);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 16; i++) begin
            wst[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            rdst[i] = $urandom_range(0, 3);
         end
         nfail = $urandom_range(0, 4);
         launch(18'($urandom), 18'($urandom), rand_c(), s);
         finish_txn(s, 1'(($urandom_range(0, 1))), 0);
      end

      // Reset during the first C write; nothing may follow.
      for (int i = 0; i < 16; i++) begin
         wst[i] = 0;
         rdst[i] = 0;
      end
      nfail = 0;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b1, 10);
      quiet = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      quiet = 1'b0;

      // Recovery after reset.
      nfail = 1;
      launch(18'($urandom), 18'($urandom), rand_c(), s);
      finish_txn(s, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
